// File: rtl/openila_capture_ctrl.sv
// openila_capture_ctrl
// Capture controller that sits after the ILA trigger unit. It drives the
// sample RAM write port as a circular buffer, keeps a programmable number of
// pre-trigger samples, fills the remainder with post-trigger samples and then
// stops. It reports the RAM address of the trigger sample and of the oldest
// sample so the host can unroll the buffer.
module openila_capture_ctrl #(
  parameter int W_DATA = 8,
  parameter int W_ADDR = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [W_DATA-1:0] sample,
  input  logic              sample_en,
  input  logic              trigger,
  input  logic              arm,
  input  logic              abort,
  input  logic [W_ADDR-1:0] pretrig_depth,
  output logic              mem_wen,
  output logic [W_ADDR-1:0] mem_waddr,
  output logic [W_DATA-1:0] mem_wdata,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic [W_ADDR-1:0] trig_addr,
  output logic [W_ADDR-1:0] start_addr
);

  // Buffer depth minus one (all ones) and the constant one, at address width.
  localparam logic [W_ADDR-1:0] LAST_IDX = '1;
  localparam logic [W_ADDR-1:0] ONE      = {{(W_ADDR-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRETRIG,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t            state;
  logic [W_ADDR-1:0] wptr;
  logic [W_ADDR-1:0] pd_reg;
  logic [W_ADDR-1:0] pre_cnt;
  logic [W_ADDR-1:0] post_left;
  logic              capturing;
  logic              wr;

  // A sample is stored only on strobed cycles of a capture, and never on a
  // cycle that is being aborted.
  always_comb begin
    capturing = (state == S_PRETRIG) || (state == S_WAIT) || (state == S_POST);
    wr        = sample_en && capturing && !abort;
  end

  assign mem_wen   = wr;
  assign mem_waddr = wptr;
  assign mem_wdata = sample;

  // Capture FSM: write pointer, depth counters, trigger/start bookkeeping and
  // the registered status flags all advance together here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wptr       <= '0;
      pd_reg     <= '0;
      pre_cnt    <= '0;
      post_left  <= '0;
      trig_addr  <= '0;
      start_addr <= '0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
    end else begin
      if (wr) begin
        wptr <= wptr + ONE;
      end

      if (abort) begin
        // Abort wins over everything, including a simultaneous arm. The
        // reported addresses are kept so a host can still inspect them.
        state     <= S_IDLE;
        busy      <= 1'b0;
        triggered <= 1'b0;
        done      <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (arm) begin
              wptr      <= '0;
              pre_cnt   <= '0;
              pd_reg    <= pretrig_depth;
              busy      <= 1'b1;
              triggered <= 1'b0;
              done      <= 1'b0;
              state     <= (pretrig_depth == '0) ? S_WAIT : S_PRETRIG;
            end
          end

          S_PRETRIG: begin
            // Triggers are not qualified until the pre-trigger window is full.
            if (wr) begin
              pre_cnt <= pre_cnt + ONE;
              if (pre_cnt == pd_reg - ONE) begin
                state <= S_WAIT;
              end
            end
          end

          S_WAIT: begin
            if (wr && trigger) begin
              trig_addr <= wptr;
              post_left <= LAST_IDX - pd_reg;
              triggered <= 1'b1;
              if (pd_reg == LAST_IDX) begin
                // The trigger sample itself completes the buffer.
                state      <= S_DONE;
                busy       <= 1'b0;
                done       <= 1'b1;
                start_addr <= wptr - pd_reg;
              end else begin
                state <= S_POST;
              end
            end
          end

          S_POST: begin
            if (wr) begin
              post_left <= post_left - ONE;
              if (post_left == ONE) begin
                state      <= S_DONE;
                busy       <= 1'b0;
                done       <= 1'b1;
                start_addr <= trig_addr - pd_reg;
              end
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_openila_capture_ctrl.sv
// Testbench for openila_capture_ctrl with a 16-entry buffer. A capture is
// modelled as the ordered list of stored samples since arm: the trigger is the
// first strobed trigger at list index >= pretrig depth, and the capture ends
// once (depth - pretrig) entries from the trigger onwards have been stored.
module tb_openila_capture_ctrl;

  localparam int WD = 8;
  localparam int WA = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [WD-1:0] sample;
  logic          sample_en;
  logic          trigger;
  logic          arm;
  logic          abort;
  logic [WA-1:0] pretrig_depth;
  logic          mem_wen;
  logic [WA-1:0] mem_waddr;
  logic [WD-1:0] mem_wdata;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [WA-1:0] trig_addr;
  logic [WA-1:0] start_addr;

  always #5 clk = ~clk;

  openila_capture_ctrl #(.W_DATA(WD), .W_ADDR(WA)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (sample),
    .sample_en    (sample_en),
    .trigger      (trigger),
    .arm          (arm),
    .abort        (abort),
    .pretrig_depth(pretrig_depth),
    .mem_wen      (mem_wen),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .triggered    (triggered),
    .done         (done),
    .trig_addr    (trig_addr),
    .start_addr   (start_addr)
  );

  // Sample RAM as seen by the host.
  logic [WD-1:0] ram [D];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit          m_active;
  bit          m_done;
  bit          m_trigf;
  int          m_pd;
  int          m_n;
  int          m_trig;
  int          m_taddr;
  int          m_saddr;
  bit          ram_pending;
  logic [WD-1:0] m_hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_trigf = 0;
    m_pd = 0; m_n = 0; m_trig = -1;
    m_taddr = 0; m_saddr = 0; ram_pending = 0;
    m_hist.delete();
  endtask

  // One clock cycle: drive inputs after the edge, check mid-cycle, then
  // advance the model to what the next edge should produce.
  task automatic cyc(input bit en, input bit trg, input bit a, input bit ab, input int pd);
    bit exp_wen;
    @(posedge clk);
    #1;
    sample_en     = en;
    trigger       = trg;
    arm           = a;
    abort         = ab;
    sample        = WD'($urandom);
    pretrig_depth = a ? WA'(pd) : WA'($urandom);
    #2;
    exp_wen = m_active && en && !ab;
    chk("mem_wen", mem_wen, exp_wen);
    if (exp_wen) begin
      chk("mem_waddr", mem_waddr, m_n % D);
      chk("mem_wdata", mem_wdata, sample);
    end
    chk("busy", busy, m_active);
    chk("triggered", triggered, m_trigf);
    chk("done", done, m_done);
    chk("trig_addr", trig_addr, m_taddr);
    chk("start_addr", start_addr, m_saddr);
    if (ram_pending) begin
      for (int i = 0; i < D; i++)
        chk("ram_order", ram[(m_saddr + i) % D], m_hist[m_trig - m_pd + i]);
      ram_pending = 0;
    end

    if (ab) begin
      m_active = 0; m_done = 0; m_trigf = 0;
    end else if (a && !m_active) begin
      m_active = 1; m_done = 0; m_trigf = 0;
      m_n = 0; m_pd = pd; m_trig = -1;
      m_hist.delete();
    end else if (m_active && en) begin
      m_hist.push_back(sample);
      if (!m_trigf && m_n >= m_pd && trg) begin
        m_trigf = 1;
        m_trig  = m_n;
        m_taddr = m_n % D;
      end
      m_n++;
      if (m_trigf && m_n == m_trig + D - m_pd) begin
        m_active    = 0;
        m_done      = 1;
        m_saddr     = ((m_trig - m_pd) % D + D) % D;
        ram_pending = 1;
      end
    end
  endtask

  task automatic run(input int pd, input int ncyc, input int trig_at);
    cyc(0, 0, 1, 0, pd);
    for (int i = 0; i < ncyc; i++) cyc(1, i == trig_at, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    sample = '0; sample_en = 0; trigger = 0; arm = 0; abort = 0; pretrig_depth = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_waddr", mem_waddr, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_start_addr", start_addr, 0);
    rst_n = 1'b1;

    // Basic capture: pretrig 4, trigger at stored sample 9.
    run(4, 30, 9);
    chk("s1_trig_addr", trig_addr, 9);
    chk("s1_start_addr", start_addr, 5);

    // Triggers inside the pre-trigger window are ignored.
    cyc(0, 0, 1, 0, 6);
    for (int i = 0; i < 30; i++) cyc(1, (i == 1) || (i == 3) || (i == 8), 0, 0, 0);
    chk("s2_trig_addr", trig_addr, 8);

    // No pre-trigger samples: straight to waiting.
    run(0, 20, 0);
    chk("s3_start_addr", start_addr, 0);

    // Maximum pre-trigger depth: trigger sample is the only post write.
    run(15, 22, 20);
    chk("s4_start_addr", start_addr, 5);

    // Triggers only on unstrobed cycles are never accepted.
    cyc(0, 0, 1, 0, 2);
    for (int i = 0; i < 20; i++) cyc(i % 2 == 0, i % 2 == 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Abort in POST together with arm: abort wins.
    run(3, 8, 5);
    cyc(1, 0, 1, 1, 9);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);

    // Re-arm from DONE with a new depth.
    run(2, 20, 4);
    run(7, 30, 10);

    // Randomised captures with strobe gaps, stray arms and occasional aborts.
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 1, 0, $urandom_range(0, 15));
      for (int i = 0; i < 80; i++)
        cyc(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 20) == 0,
            ($urandom % 60) == 0, $urandom_range(0, 15));
    end

    // Asynchronous reset in the middle of POST.
    run(1, 6, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_triggered", triggered, 0);
    chk("arst_done", done, 0);
    chk("arst_mem_wen", mem_wen, 0);
    chk("arst_waddr", mem_waddr, 0);
    chk("arst_trig_addr", trig_addr, 0);
    chk("arst_start_addr", start_addr, 0);
    model_reset();
    arm = 0; abort = 0;
    @(posedge clk);
    #4;
    rst_n = 1'b1;

    // Clean capture after the reset.
    run(5, 30, 7);
    cyc(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
